// File: rtl/shutter_sched.sv
// Camera shutter scheduler: round-robin grant between two requesters, then a
// gap, N shutter pulses with settle time, and a skippable processing window.
module shutter_sched #(
    parameter int GAP_CYC    = 3,
    parameter int SETTLE_CYC = 2,
    parameter int PROC_CYC   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic [2:0] shots0,
    input  logic [2:0] shots1,
    input  logic       skip,
    output logic [1:0] gnt,
    output logic       shutter,
    output logic       busy,
    output logic [1:0] done,
    output logic [2:0] shots_left
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        GAP     = 3'd1,
        SHOT    = 3'd2,
        SETTLE  = 3'd3,
        PROCESS = 3'd4
    } state_t;

    localparam logic [3:0] GAP_LD    = 4'(GAP_CYC - 1);
    localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYC - 1);
    localparam logic [3:0] PROC_LD   = 4'(PROC_CYC - 1);

    state_t     state_q;
    logic [3:0] cnt_q;
    logic [1:0] gnt_q;
    logic       shutter_q;
    logic       busy_q;
    logic [1:0] done_q;
    logic [2:0] shotsLeft_q;
    logic       lastServed_q;

    logic [1:0] winner_d;
    logic [2:0] shotCount_d;

    // On a tie the requester that was not served last wins.
    always_comb begin
        winner_d = 2'b00;
        case (req)
            2'b01:   winner_d = 2'b01;
            2'b10:   winner_d = 2'b10;
            2'b11:   winner_d = lastServed_q ? 2'b01 : 2'b10;
            default: winner_d = 2'b00;
        endcase
        shotCount_d = winner_d[1] ? shots1 : shots0;
        if (shotCount_d == 3'd0) begin
            shotCount_d = 3'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            gnt_q        <= 2'b00;
            shutter_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 2'b00;
            shotsLeft_q  <= 3'd0;
            lastServed_q <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 2'b00;
                    if (winner_d != 2'b00) begin
                        state_q     <= GAP;
                        gnt_q       <= winner_d;
                        busy_q      <= 1'b1;
                        shotsLeft_q <= shotCount_d;
                        cnt_q       <= GAP_LD;
                    end
                end
                GAP: begin
                    if (cnt_q == 4'd0) begin
                        state_q   <= SHOT;
                        shutter_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                SHOT: begin
                    state_q     <= SETTLE;
                    shutter_q   <= 1'b0;
                    shotsLeft_q <= shotsLeft_q - 3'd1;
                    cnt_q       <= SETTLE_LD;
                end
                SETTLE: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else if (shotsLeft_q != 3'd0) begin
                        state_q   <= SHOT;
                        shutter_q <= 1'b1;
                    end else begin
                        state_q <= PROCESS;
                        cnt_q   <= PROC_LD;
                    end
                end
                PROCESS: begin
                    // skip sampled in any PROCESS cycle closes the session at this edge
                    if (cnt_q == 4'd0 || skip) begin
                        state_q      <= IDLE;
                        gnt_q        <= 2'b00;
                        busy_q       <= 1'b0;
                        done_q       <= gnt_q;
                        lastServed_q <= gnt_q[1];
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    cnt_q       <= 4'd0;
                    gnt_q       <= 2'b00;
                    shutter_q   <= 1'b0;
                    busy_q      <= 1'b0;
                    done_q      <= 2'b00;
                    shotsLeft_q <= 3'd0;
                end
            endcase
        end
    end

    assign gnt        = gnt_q;
    assign shutter    = shutter_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign shots_left = shotsLeft_q;

endmodule

// File: tb/tb_shutter_sched.sv
// Directed bench for shutter_sched: whole sessions are checked cycle by cycle
// against hand-derived timing (grant edge = cycle 0).
module tb_shutter_sched;

    logic       clk;
    logic       reset;
    logic [1:0] req;
    logic [2:0] shots0;
    logic [2:0] shots1;
    logic       skip;
    logic [1:0] gnt;
    logic       shutter;
    logic       busy;
    logic [1:0] done;
    logic [2:0] shots_left;

    int total = 0;
    int bad   = 0;

    shutter_sched dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .shots0     (shots0),
        .shots1     (shots1),
        .skip       (skip),
        .gnt        (gnt),
        .shutter    (shutter),
        .busy       (busy),
        .done       (done),
        .shots_left (shots_left)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        total++;
        if (observed != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic checkCleared(input string tag);
        checkOutput({tag, ".gnt"}, int'(gnt), 0);
        checkOutput({tag, ".shutter"}, int'(shutter), 0);
        checkOutput({tag, ".busy"}, int'(busy), 0);
        checkOutput({tag, ".done"}, int'(done), 0);
        checkOutput({tag, ".shots_left"}, int'(shots_left), 0);
    endtask

    // Caller has req/shots set during an IDLE cycle; the next edge is the grant
    // edge. Shot k fires in cycle 4+3k, PROCESS starts at 4+3N, done follows it.
    task automatic applyStimulus(input int owner, input int n, input bit useSkip,
                                 input bit holdReq, input string tag);
        int procStart;
        int cEnd;
        int fired;
        procStart = 4 + 3 * n;
        cEnd      = procStart + (useSkip ? 1 : 4);
        stepCycle();
        if (!holdReq) req = 2'b00;
        shots0 = 3'd7;
        shots1 = 3'd7;
        for (int c = 1; c <= cEnd; c++) begin
            fired = (c <= 4) ? 0 : ((c - 2) / 3 > n ? n : (c - 2) / 3);
            checkOutput($sformatf("%s.c%0d.gnt", tag, c), int'(gnt), c < cEnd ? owner : 0);
            checkOutput($sformatf("%s.c%0d.busy", tag, c), int'(busy), c < cEnd ? 1 : 0);
            checkOutput($sformatf("%s.c%0d.shutter", tag, c), int'(shutter),
                        (c >= 4 && c < procStart && (c - 4) % 3 == 0) ? 1 : 0);
            checkOutput($sformatf("%s.c%0d.shots_left", tag, c), int'(shots_left), n - fired);
            checkOutput($sformatf("%s.c%0d.done", tag, c), int'(done), c == cEnd ? owner : 0);
            skip = (c == 4) || (c == 5) || (useSkip && c == procStart);
            if (c < cEnd) stepCycle();
            skip = 1'b0;
        end
    endtask

    task automatic pulseReset();
        reset = 1'b1;
        stepCycle();
        stepCycle();
        reset = 1'b0;
    endtask

    initial begin
        reset  = 1'b1;
        req    = 2'b00;
        shots0 = 3'd0;
        shots1 = 3'd0;
        skip   = 1'b0;
        stepCycle();
        stepCycle();
        checkCleared("reset");
        reset = 1'b0;
        stepCycle();

        $display("[TB] two shots from requester 0, inputs changed while busy");
        req = 2'b01; shots0 = 3'd2;
        applyStimulus(1, 2, 1'b0, 1'b0, "basic");
        stepCycle();
        checkOutput("basic.doneDrop", int'(done), 0);

        $display("[TB] shots1=0 treated as one shot");
        req = 2'b10; shots1 = 3'd0;
        applyStimulus(2, 1, 1'b0, 1'b0, "zeroShots");
        stepCycle();

        $display("[TB] skip in first PROCESS cycle");
        req = 2'b01; shots0 = 3'd2;
        applyStimulus(1, 2, 1'b1, 1'b0, "skip");
        stepCycle();

        $display("[TB] round robin with both requesting");
        pulseReset();
        req = 2'b11; shots0 = 3'd1; shots1 = 3'd1;
        applyStimulus(1, 1, 1'b0, 1'b1, "rr0");
        shots0 = 3'd1; shots1 = 3'd1;
        applyStimulus(2, 1, 1'b0, 1'b1, "rr1");
        shots0 = 3'd1; shots1 = 3'd1;
        applyStimulus(1, 1, 1'b0, 1'b0, "rr2");
        stepCycle();

        $display("[TB] reset during SETTLE");
        req = 2'b01; shots0 = 3'd3;
        stepCycle();
        req = 2'b00;
        for (int i = 0; i < 4; i++) stepCycle();
        checkOutput("abort.preShots", int'(shots_left), 2);
        #2;
        reset = 1'b1;
        #1;
        checkCleared("abort.async");
        stepCycle();
        stepCycle();
        checkCleared("abort.held");
        reset = 1'b0;
        stepCycle();
        checkOutput("abort.noDone", int'(done), 0);
        req = 2'b01; shots0 = 3'd3;
        applyStimulus(1, 3, 1'b0, 1'b0, "restart");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
